// File: rtl/puf_ctrl_pkg.sv
// Shared types and constants for the PUF challenge sequencer and its voter.
package puf_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    EVAL,
    HOLD,
    OUTPUT
  } state_t;

  localparam int DEF_CHAL_W     = 8;
  localparam int DEF_RESP_W     = 16;
  localparam int DEF_SETTLE_CYC = 16;
  localparam int DEF_EVAL_CYC   = 1024;
  localparam int DEF_VOTES      = 3;

  // Counter width able to hold every count from 0 up to votes inclusive.
  function automatic int vote_cnt_w(input int votes);
    return $clog2(votes + 1);
  endfunction

endpackage

// File: rtl/majority_voter.sv
// Per-bit vote counters for one challenge plus the majority threshold.
// maj_next already includes a vector being added this cycle, so the
// caller can register the final vote on the same edge as the last add.
module majority_voter import puf_ctrl_pkg::*; #(
  parameter int RESP_W = DEF_RESP_W,
  parameter int VOTES  = DEF_VOTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              add,
  input  logic [RESP_W-1:0] vec,
  output logic [RESP_W-1:0] maj_next
);

  localparam int CNT_W  = vote_cnt_w(VOTES);
  localparam int THRESH = VOTES / 2;

  logic [CNT_W-1:0] cnt [RESP_W];

  // Count the ones seen on each bit since the last clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RESP_W; i++) cnt[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < RESP_W; i++) cnt[i] <= '0;
    end else if (add) begin
      for (int i = 0; i < RESP_W; i++) cnt[i] <= cnt[i] + CNT_W'(vec[i]);
    end
  end

  // Strict majority over the counts, including a pending add.
  always_comb begin
    maj_next = '0;
    for (int i = 0; i < RESP_W; i++) begin
      maj_next[i] = (int'(cnt[i]) + int'(add & vec[i])) > THRESH;
    end
  end

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Walks the RO PUF array through a run of challenges, majority-votes
// several evaluations per challenge and hands each voted response out
// on a valid/ready port.
//
// state  | meaning
// IDLE   | waiting for start, all outputs low
// CLEAR  | ro_clr held for SETTLE_CYC cycles
// EVAL   | ro_en held for EVAL_CYC cycles
// HOLD   | 2 quiet cycles, response voted on the last one
// OUTPUT | voted response offered until accepted
module puf_challenge_sequencer import puf_ctrl_pkg::*; #(
  parameter int CHAL_W     = DEF_CHAL_W,
  parameter int RESP_W     = DEF_RESP_W,
  parameter int SETTLE_CYC = DEF_SETTLE_CYC,
  parameter int EVAL_CYC   = DEF_EVAL_CYC,
  parameter int VOTES      = DEF_VOTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [CHAL_W-1:0] chal_base,
  input  logic [CHAL_W-1:0] chal_count,
  output logic [CHAL_W-1:0] ro_challenge,
  output logic              ro_en,
  output logic              ro_clr,
  input  logic [RESP_W-1:0] ro_resp,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [RESP_W-1:0] resp_data,
  output logic [CHAL_W-1:0] resp_chal,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W   = vote_cnt_w(VOTES);
  localparam int TMR_MAX = (SETTLE_CYC > EVAL_CYC) ?
                           ((SETTLE_CYC > 2) ? SETTLE_CYC : 2) :
                           ((EVAL_CYC > 2) ? EVAL_CYC : 2);
  localparam int TMR_W   = $clog2(TMR_MAX);

  state_t            state;
  logic [TMR_W-1:0]  tmr;
  logic [CHAL_W:0]   remaining;
  logic [CNT_W-1:0]  vote_idx;
  logic [CHAL_W-1:0] cur_chal;
  logic [RESP_W-1:0] resp_sync1;
  logic [RESP_W-1:0] resp_sync2;
  logic [RESP_W-1:0] maj_next;
  logic              voter_clr;
  logic              voter_add;

  assign ro_challenge = cur_chal;

  // ro_resp comes from free-running oscillators; bring it into clk domain.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      resp_sync1 <= '0;
      resp_sync2 <= '0;
    end else begin
      resp_sync1 <= ro_resp;
      resp_sync2 <= resp_sync1;
    end
  end

  assign voter_clr = ((state == IDLE) && start) || ((state == OUTPUT) && resp_ready);
  assign voter_add = (state == HOLD) && (tmr == '0);

  majority_voter #(
    .RESP_W (RESP_W),
    .VOTES  (VOTES)
  ) u_voter (
    .clk      (clk),
    .rst      (rst),
    .clr      (voter_clr),
    .add      (voter_add),
    .vec      (resp_sync2),
    .maj_next (maj_next)
  );

  // Sequencing FSM; every output is a register updated here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      tmr        <= '0;
      remaining  <= '0;
      vote_idx   <= '0;
      cur_chal   <= '0;
      ro_en      <= 1'b0;
      ro_clr     <= 1'b0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_chal  <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        // A handshake coinciding with abort still transfers; just no done.
        state      <= IDLE;
        tmr        <= '0;
        cur_chal   <= '0;
        ro_en      <= 1'b0;
        ro_clr     <= 1'b0;
        resp_valid <= 1'b0;
        resp_data  <= '0;
        resp_chal  <= '0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              state     <= CLEAR;
              busy      <= 1'b1;
              ro_clr    <= 1'b1;
              cur_chal  <= chal_base;
              remaining <= (chal_count == '0) ? {1'b1, {CHAL_W{1'b0}}} : {1'b0, chal_count};
              vote_idx  <= '0;
              tmr       <= TMR_W'(SETTLE_CYC - 1);
            end
          end
          CLEAR: begin
            if (tmr == '0) begin
              state  <= EVAL;
              ro_clr <= 1'b0;
              ro_en  <= 1'b1;
              tmr    <= TMR_W'(EVAL_CYC - 1);
            end else begin
              tmr <= tmr - TMR_W'(1);
            end
          end
          EVAL: begin
            if (tmr == '0) begin
              state <= HOLD;
              ro_en <= 1'b0;
              tmr   <= TMR_W'(1);
            end else begin
              tmr <= tmr - TMR_W'(1);
            end
          end
          HOLD: begin
            if (tmr == '0) begin
              if (vote_idx < CNT_W'(VOTES - 1)) begin
                state    <= CLEAR;
                vote_idx <= vote_idx + CNT_W'(1);
                ro_clr   <= 1'b1;
                tmr      <= TMR_W'(SETTLE_CYC - 1);
              end else begin
                state      <= OUTPUT;
                resp_valid <= 1'b1;
                resp_data  <= maj_next;
                resp_chal  <= cur_chal;
              end
            end else begin
              tmr <= tmr - TMR_W'(1);
            end
          end
          OUTPUT: begin
            if (resp_ready) begin
              resp_valid <= 1'b0;
              if (remaining == (CHAL_W+1)'(1)) begin
                state     <= IDLE;
                busy      <= 1'b0;
                done      <= 1'b1;
                cur_chal  <= '0;
                resp_data <= '0;
                resp_chal <= '0;
              end else begin
                state     <= CLEAR;
                cur_chal  <= cur_chal + CHAL_W'(1);
                remaining <= remaining - (CHAL_W+1)'(1);
                vote_idx  <= '0;
                ro_clr    <= 1'b1;
                tmr       <= TMR_W'(SETTLE_CYC - 1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Bench for puf_challenge_sequencer: a phase-arithmetic reference model,
// a per-cycle compare process and directed/randomized scenarios.
module tb_puf_challenge_sequencer;

  localparam int CHAL_W = 8;
  localparam int RESP_W = 16;
  localparam int SETTLE = 2;
  localparam int EVALC  = 8;
  localparam int VOTES  = 3;
  localparam int EV_CYC = SETTLE + EVALC + 2;
  localparam int CH_CYC = VOTES * EV_CYC;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              abort;
  logic [CHAL_W-1:0] chal_base;
  logic [CHAL_W-1:0] chal_count;
  logic [CHAL_W-1:0] ro_challenge;
  logic              ro_en;
  logic              ro_clr;
  logic [RESP_W-1:0] ro_resp;
  logic              resp_valid;
  logic              resp_ready;
  logic [RESP_W-1:0] resp_data;
  logic [CHAL_W-1:0] resp_chal;
  logic              busy;
  logic              done;

  puf_challenge_sequencer #(
    .CHAL_W     (CHAL_W),
    .RESP_W     (RESP_W),
    .SETTLE_CYC (SETTLE),
    .EVAL_CYC   (EVALC),
    .VOTES      (VOTES)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .chal_base    (chal_base),
    .chal_count   (chal_count),
    .ro_challenge (ro_challenge),
    .ro_en        (ro_en),
    .ro_clr       (ro_clr),
    .ro_resp      (ro_resp),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_chal    (resp_chal),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the run is a cycle offset m_k from the
  // start of the current challenge; evaluations are EV_CYC cycles each.
  logic              m_busy = 1'b0;
  int                m_k    = 0;
  logic [CHAL_W-1:0] m_chal = '0;
  int                m_rem  = 0;
  logic              m_done = 1'b0;
  logic [RESP_W-1:0] vq[$];
  logic [RESP_W-1:0] pat_q[$];
  logic [CHAL_W-1:0] rx_q[$];
  int                n_done = 0;

  function automatic logic [RESP_W-1:0] maj_exp();
    logic [RESP_W-1:0] r;
    r = '0;
    for (int b = 0; b < RESP_W; b++) begin
      int ones;
      ones = 0;
      foreach (vq[j]) ones += int'(vq[j][b]);
      r[b] = (ones > VOTES / 2);
    end
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0;
      m_k    = 0;
      m_chal = '0;
      m_rem  = 0;
      m_done = 1'b0;
      vq.delete();
    end else begin
      m_done = 1'b0;
      if (!m_busy) begin
        if (start && !abort) begin
          m_busy = 1'b1;
          m_k    = 0;
          m_chal = chal_base;
          m_rem  = (chal_count == 0) ? 256 : int'(chal_count);
          vq.delete();
        end
      end else if (abort) begin
        m_busy = 1'b0;
      end else if (m_k >= CH_CYC) begin
        if (resp_ready) begin
          if (m_rem == 1) begin
            m_busy = 1'b0;
            m_done = 1'b1;
          end else begin
            m_chal = m_chal + 8'd1;
            m_rem  = m_rem - 1;
            m_k    = 0;
            vq.delete();
          end
        end
      end else begin
        if (m_k % EV_CYC == EV_CYC - 1) vq.push_back(ro_resp);
        m_k++;
      end
    end
  end

  // Response source: one value held for each whole evaluation, junk otherwise.
  always @(posedge clk) begin
    #1;
    if (m_busy && m_k < CH_CYC) begin
      if (m_k % EV_CYC == 0) begin
        if (pat_q.size() > 0) ro_resp = pat_q.pop_front();
        else ro_resp = 16'($urandom);
      end
    end else begin
      ro_resp = 16'($urandom);
    end
  end

  // Per-cycle compare against the model, plus handshake/done monitors.
  logic [12:0] exp_ctl;
  logic        e_en, e_clr, e_val;
  int          r_pos;
  always @(negedge clk) begin
    e_en  = 1'b0;
    e_clr = 1'b0;
    e_val = 1'b0;
    if (m_busy) begin
      if (m_k >= CH_CYC) e_val = 1'b1;
      else begin
        r_pos = m_k % EV_CYC;
        e_clr = (r_pos < SETTLE);
        e_en  = (r_pos >= SETTLE) && (r_pos < SETTLE + EVALC);
      end
    end
    exp_ctl = {m_busy, e_en, e_clr, e_val, m_done, (m_busy ? m_chal : 8'h00)};
    check("ctl{busy,en,clr,valid,done,chal}",
          64'({busy, ro_en, ro_clr, resp_valid, done, ro_challenge}), 64'(exp_ctl));
    if (!m_busy)
      check("idle_resp", 64'({resp_data, resp_chal}), 64'(0));
    else if (m_k >= CH_CYC)
      check("resp{data,chal}", 64'({resp_data, resp_chal}), 64'({maj_exp(), m_chal}));
    if (resp_valid && resp_ready) rx_q.push_back(resp_chal);
    if (done) n_done++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(input logic [CHAL_W-1:0] base, input logic [CHAL_W-1:0] cnt);
    chal_base  = base;
    chal_count = cnt;
    start      = 1'b1;
    step();
    start      = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output int lat);
    lat = 0;
    while (!resp_valid && lat < bound) begin
      step();
      lat++;
    end
  endtask

  task automatic wait_done(input int bound, input int d0, input bit rnd_ready);
    int c;
    c = 0;
    while (n_done == d0 && c < bound) begin
      if (rnd_ready) resp_ready = 1'($urandom_range(0, 1));
      step();
      c++;
    end
    resp_ready = 1'b1;
  endtask

  int lat, d0, n0, c, act_cnt, bad;

  initial begin
    rst        = 1'b0;
    start      = 1'b0;
    abort      = 1'b0;
    resp_ready = 1'b1;
    chal_base  = '0;
    chal_count = '0;
    ro_resp    = '0;
    repeat (3) step();
    check("reset_outputs",
          64'({ro_challenge, ro_en, ro_clr, resp_valid, resp_data, resp_chal, busy, done}), 64'(0));
    rst = 1'b1;
    step();

    // single challenge, fixed response
    repeat (3) pat_q.push_back(16'hBEEF);
    d0 = n_done;
    pulse_start(8'h5A, 8'd1);
    wait_valid(100, lat);
    check("single_latency", 64'(lat), 64'(36));
    check("single_data", 64'(resp_data), 64'(16'hBEEF));
    check("single_chal", 64'(resp_chal), 64'(8'h5A));
    step();
    check("single_done", 64'({done, busy}), 64'(2'b10));
    step();
    check("single_done_count", 64'(n_done - d0), 64'(1));

    // majority across three differing evaluations
    pat_q.push_back(16'h00FF);
    pat_q.push_back(16'h0F0F);
    pat_q.push_back(16'h0FF0);
    pulse_start(8'($urandom), 8'd1);
    wait_valid(100, lat);
    check("majority_data", 64'(resp_data), 64'(16'h0FFF));
    repeat (2) step();

    // wrap with count 0 = 256 challenges
    rx_q.delete();
    d0 = n_done;
    pulse_start(8'hFE, 8'd0);
    wait_done(256 * (CH_CYC + 2) + 100, d0, 1'b0);
    step();
    check("wrap_count", 64'(rx_q.size()), 64'(256));
    check("wrap_done_count", 64'(n_done - d0), 64'(1));
    if (rx_q.size() == 256) begin
      check("wrap_first", 64'(rx_q[0]), 64'(8'hFE));
      check("wrap_cross", 64'({rx_q[1], rx_q[2]}), 64'(16'hFF00));
      check("wrap_last", 64'(rx_q[255]), 64'(8'hFD));
      bad = 0;
      for (int i = 0; i < 256; i++) if (int'(rx_q[i]) != ((254 + i) % 256)) bad++;
      check("wrap_sequence", 64'(bad), 64'(0));
    end

    // backpressure
    d0 = n_done;
    pulse_start(8'($urandom), 8'd2);
    wait_valid(100, lat);
    check("bp_valid_seen", 64'(resp_valid), 64'(1));
    resp_ready = 1'b0;
    act_cnt = 0;
    repeat (50) begin
      step();
      if (ro_en || ro_clr || !resp_valid) act_cnt++;
    end
    check("bp_held", 64'(act_cnt), 64'(0));
    resp_ready = 1'b1;
    wait_done(200, d0, 1'b0);
    check("bp_done", 64'(n_done - d0), 64'(1));

    // start while busy is ignored
    rx_q.delete();
    d0 = n_done;
    pulse_start(8'h10, 8'd2);
    repeat (5) step();
    pulse_start(8'h80, 8'd5);
    wait_done(200, d0, 1'b0);
    step();
    check("busy_start_count", 64'(rx_q.size()), 64'(2));
    if (rx_q.size() == 2) check("busy_start_chals", 64'({rx_q[0], rx_q[1]}), 64'(16'h1011));

    // abort mid-EVAL, then start+abort in IDLE, then a normal run
    d0 = n_done;
    pulse_start(8'($urandom_range(1, 255)), 8'd3);
    repeat (4) step();
    check("pre_abort_en", 64'(ro_en), 64'(1));
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_outputs",
          64'({ro_challenge, ro_en, ro_clr, resp_valid, busy, done}), 64'(0));
    start = 1'b1;
    abort = 1'b1;
    step();
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_idle", 64'({busy, ro_clr}), 64'(0));
    step();
    check("abort_no_done", 64'(n_done - d0), 64'(0));
    pulse_start(8'($urandom), 8'd2);
    wait_done(200, d0, 1'b0);
    check("after_abort_run", 64'(n_done - d0), 64'(1));

    // abort coinciding with a handshake
    n0 = rx_q.size();
    d0 = n_done;
    pulse_start(8'($urandom), 8'd3);
    wait_valid(100, lat);
    abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort_hs_busy", 64'(busy), 64'(0));
    repeat (2) step();
    check("abort_hs_xfer", 64'(rx_q.size() - n0), 64'(1));
    check("abort_hs_no_done", 64'(n_done - d0), 64'(0));

    // async reset in the middle of HOLD
    pulse_start(8'($urandom) | 8'h01, 8'd1);
    c = 0;
    while (!(m_busy && m_k == SETTLE + EVALC) && c < 50) begin
      step();
      c++;
    end
    check("reached_hold", 64'(busy), 64'(1));
    rst = 1'b0;
    #1;
    check("async_reset_outputs",
          64'({ro_challenge, ro_en, ro_clr, resp_valid, resp_data, resp_chal, busy, done}), 64'(0));
    repeat (2) step();
    rst = 1'b1;
    step();

    // randomized runs with random backpressure
    for (int run = 0; run < 4; run++) begin
      d0 = n_done;
      pulse_start(8'($urandom), 8'($urandom_range(1, 4)));
      wait_done(2000, d0, 1'b1);
      check("random_run_done", 64'(n_done - d0), 64'(1));
      repeat (2) step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
